branch_predictor: RTL and testbench
===================================

BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 Parameter BTB_IDX_W, default 6: the BTB has 2^BTB_IDX_W direct-mapped entries.
REQ-002 Parameter PHT_IDX_W, default 8: the PHT has 2^PHT_IDX_W 2-bit counters, and the GHR is PHT_IDX_W bits wide.
REQ-003 Parameter RAS_DEPTH, default 8, a power of two >= 2: return-address-stack entry count.
REQ-004 clk  input  1  clock; all state changes on the rising edge.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 lookup_en  input  1  prediction request for lookup_pc.
REQ-007 lookup_pc  input  32  fetch PC, word aligned.
REQ-008 pred_valid  output  1  prediction outputs are valid this cycle.
REQ-009 pred_hit  output  1  BTB tag hit.
REQ-010 pred_taken  output  1  predicted taken.
REQ-011 pred_target  output  32  predicted next PC.
REQ-012 update_en  input  1  resolved control-transfer instruction.
REQ-013 update_pc  input  32  PC of the resolved instruction.
REQ-014 update_type  input  2  0 = conditional branch, 1 = jump, 2 = call (JAL/JALR), 3 = return (JR $ra).
REQ-015 update_taken  input  1  resolved direction; 1 for types 1-3.
REQ-016 update_target  input  32  resolved target.
REQ-017 update_mispredict  input  1  the earlier prediction for this instruction was wrong.
REQ-018 mispredict_cnt  output  32  saturating count of mispredicts.

Function
REQ-019 Address split: BTB index = pc[BTB_IDX_W+1:2]; tag = pc[31:BTB_IDX_W+2].
REQ-020 PHT index = pc[PHT_IDX_W+1:2] XOR GHR.
REQ-021 Each BTB entry holds valid, tag, 32-bit target and 2-bit type.
REQ-022 Prediction latency is 1 cycle: lookup_en at edge t produces registered outputs after edge t, valid during cycle t+1.
REQ-023 pred_valid is lookup_en delayed by one cycle; when pred_valid=0 the other prediction outputs hold their previous values.
REQ-024 Miss (no valid tag match): pred_hit=0, pred_taken=0, pred_target=lookup_pc+4.
REQ-025 Hit, type 0: pred_taken = PHT counter bit 1; pred_target = BTB target when taken, else lookup_pc+4.
REQ-026 Hit, type 1 or 2: pred_taken=1, pred_target = BTB target.
REQ-027 Hit, type 3 with RAS non-empty: pred_taken=1, pred_target = RAS top. With RAS empty: pred_target = BTB target.
REQ-028 Lookup and update in the same cycle: the lookup sees the pre-update state (read-before-write) for the BTB, PHT, GHR and RAS.
REQ-029 On update_en with update_taken=1: write the BTB entry at update_pc's index (valid=1, tag, target, type), overwriting any previous occupant.
REQ-030 On update_en, type 0, not taken: no BTB allocation; an existing entry is kept unchanged.
REQ-031 On update_en, type 0: the PHT counter at the index computed with the current GHR saturates up when taken (max 3) and down when not taken (min 0).
REQ-032 After the PHT update, GHR <= {GHR[PHT_IDX_W-2:0], update_taken}.
REQ-033 GHR and PHT are unchanged for types 1-3.
REQ-034 Type 2: push update_pc+8 (past the delay slot) onto the RAS.
REQ-035 RAS full on push: overwrite the oldest entry circularly; count saturates at RAS_DEPTH.
REQ-036 Type 3: pop the RAS.
REQ-037 RAS empty on pop: no change, no underflow.
REQ-038 History and RAS are updated non-speculatively, from update_* only.
REQ-039 mispredict_cnt increments by 1 on update_en & update_mispredict and saturates at 32'hFFFFFFFF.

Reset
REQ-040 While rst=1, regardless of clk: all BTB valid bits=0, all PHT counters=2'b01, GHR=0, RAS pointer and count=0, mispredict_cnt=0, pred_valid/pred_hit/pred_taken=0, pred_target=0.
REQ-041 Reset asserted mid-operation discards any pending lookup; pred_valid=0 in the first cycle after deassertion.
REQ-042 BTB target/tag storage and RAS data are not required to be cleared on reset.

Verification
REQ-043 Bench scenario, cold miss: after reset, lookup 0x00400000 -> next cycle pred_valid=1, pred_hit=0, pred_taken=0, target 0x00400004.
REQ-044 Bench scenario, counter training: update 0x00400010 type 0 taken target 0x00400100 twice, then lookup 0x00400010 -> hit, taken=1, target 0x00400100. Then four not-taken updates -> taken=0, target 0x00400014.
REQ-045 Bench scenario, call/return: update 0x00400020 type 2 target 0x00401000; update 0x00401010 type 3 target 0x00400028; lookup 0x00401010 -> taken, target 0x00400028 from the BTB (RAS now empty). Push again, then lookup -> target = RAS top 0x00400028.
REQ-046 Bench scenario, RAS overflow: RAS_DEPTH+1 calls with return addresses A0..A8, then 8 pops -> return addresses A8..A1 in order; a 9th pop leaves the RAS empty and unchanged.
REQ-047 Bench scenario, aliasing and same-cycle update: update 0x00400000 and then 0x00400100 (same index, BTB_IDX_W=6) -> lookup 0x00400000 misses. A lookup issued in the same cycle as a taken update of its own PC -> miss.
REQ-048 Bench scenario, counter saturation and reset: force mispredict_cnt to 32'hFFFFFFFF, apply a mispredict update -> count stays 32'hFFFFFFFF. Assert rst asynchronously between edges -> all outputs 0 immediately.

Source files
------------

// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - BTB + gshare PHT + return-address-stack branch predictor
//
// Purpose:
//    Single-cycle-latency next-PC predictor. A direct-mapped BTB identifies
//    control-transfer instructions and supplies their target. Conditional
//    branches are steered by a gshare pattern history table. Returns use a
//    circular return-address stack. All predictor state is trained only from
//    resolved instructions (update_*), never speculatively from lookups.
//
// Ports:
//    clk               clock, all state changes on the rising edge
//    rst               asynchronous active-high reset
//    lookup_en         prediction request for lookup_pc
//    lookup_pc[31:0]   fetch PC (word aligned)
//    pred_valid        prediction outputs valid (lookup_en delayed one cycle)
//    pred_hit          BTB tag hit
//    pred_taken        predicted taken
//    pred_target[31:0] predicted next PC
//    update_en         a resolved control-transfer instruction is presented
//    update_pc[31:0]   PC of the resolved instruction
//    update_type[1:0]  0 branch, 1 jump, 2 call, 3 return
//    update_taken      resolved direction (1 for types 1-3)
//    update_target     resolved target
//    update_mispredict the earlier prediction for this instruction was wrong
//    mispredict_cnt    saturating mispredict counter

module branch_predictor #(
   parameter int BTB_IDX_W = 6,
   parameter int PHT_IDX_W = 8,
   parameter int RAS_DEPTH = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        lookup_en,
   input  logic [31:0] lookup_pc,
   output logic        pred_valid,
   output logic        pred_hit,
   output logic        pred_taken,
   output logic [31:0] pred_target,
   input  logic        update_en,
   input  logic [31:0] update_pc,
   input  logic [1:0]  update_type,
   input  logic        update_taken,
   input  logic [31:0] update_target,
   input  logic        update_mispredict,
   output logic [31:0] mispredict_cnt
);

   localparam int BTB_N  = 1 << BTB_IDX_W;
   localparam int TAG_W  = 30 - BTB_IDX_W;
   localparam int PHT_N  = 1 << PHT_IDX_W;
   localparam int RAS_PW = $clog2(RAS_DEPTH);
   localparam int RAS_CW = RAS_PW + 1;

   localparam logic [RAS_PW-1:0] RAS_PTR_ONE = RAS_PW'(1);
   localparam logic [RAS_CW-1:0] RAS_CNT_ONE = RAS_CW'(1);
   localparam logic [RAS_CW-1:0] RAS_FULL    = RAS_CW'(RAS_DEPTH);

   localparam logic [1:0] TYPE_BRANCH = 2'd0;
   localparam logic [1:0] TYPE_CALL   = 2'd2;
   localparam logic [1:0] TYPE_RETURN = 2'd3;

   // ---------------------------------------------------------------
   // Storage
   // ---------------------------------------------------------------
   logic [BTB_N-1:0] r_btb_valid;
   logic [TAG_W-1:0] r_btb_tag  [BTB_N];
   logic [31:0]      r_btb_tgt  [BTB_N];
   logic [1:0]       r_btb_type [BTB_N];

   logic [1:0]           r_pht [PHT_N];
   logic [PHT_IDX_W-1:0] r_ghr;

   logic [31:0]       r_ras [RAS_DEPTH];
   logic [RAS_PW-1:0] r_ras_ptr;   // next free slot; top of stack is r_ras_ptr-1
   logic [RAS_CW-1:0] r_ras_cnt;

   logic [31:0] r_misp_cnt;

   logic        r_pred_valid;
   logic        r_pred_hit;
   logic        r_pred_taken;
   logic [31:0] r_pred_target;

   // ---------------------------------------------------------------
   // Lookup path (reads pre-update state of every structure)
   // ---------------------------------------------------------------
   logic [BTB_IDX_W-1:0] w_lk_idx;
   logic [TAG_W-1:0]     w_lk_tag;
   logic                 w_lk_hit;
   logic [PHT_IDX_W-1:0] w_lk_pht_idx;
   logic [31:0]          w_lk_seq;
   logic [RAS_PW-1:0]    w_ras_top_ptr;
   logic [31:0]          w_ras_top;
   logic                 w_ras_empty;
   logic                 w_lk_taken;
   logic [31:0]          w_lk_target;
   logic                 w_pht_taken;

   assign w_lk_idx      = lookup_pc[BTB_IDX_W+1:2];
   assign w_lk_tag      = lookup_pc[31:BTB_IDX_W+2];
   assign w_lk_hit      = r_btb_valid[w_lk_idx] && (r_btb_tag[w_lk_idx] == w_lk_tag);
   assign w_lk_pht_idx  = lookup_pc[PHT_IDX_W+1:2] ^ r_ghr;
   assign w_lk_seq      = lookup_pc + 32'd4;
   assign w_ras_top_ptr = r_ras_ptr - RAS_PTR_ONE;
   assign w_ras_top     = r_ras[w_ras_top_ptr];
   assign w_ras_empty   = (r_ras_cnt == '0);
   assign w_pht_taken   = r_pht[w_lk_pht_idx][1];

   always_comb begin
      w_lk_taken  = 1'b0;
      w_lk_target = w_lk_seq;
      if (w_lk_hit) begin
         case (r_btb_type[w_lk_idx])
            TYPE_BRANCH: begin
               w_lk_taken = w_pht_taken;
               if (w_pht_taken) begin
                  w_lk_target = r_btb_tgt[w_lk_idx];
               end
            end
            TYPE_RETURN: begin
               w_lk_taken  = 1'b1;
               // An empty stack falls back to the last seen return target.
               w_lk_target = w_ras_empty ? r_btb_tgt[w_lk_idx] : w_ras_top;
            end
            default: begin
               w_lk_taken  = 1'b1;
               w_lk_target = r_btb_tgt[w_lk_idx];
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pred_valid  <= 1'b0;
         r_pred_hit    <= 1'b0;
         r_pred_taken  <= 1'b0;
         r_pred_target <= 32'd0;
      end else begin
         r_pred_valid <= lookup_en;
         if (lookup_en) begin
            r_pred_hit    <= w_lk_hit;
            r_pred_taken  <= w_lk_taken;
            r_pred_target <= w_lk_target;
         end
      end
   end

   assign pred_valid  = r_pred_valid;
   assign pred_hit    = r_pred_hit;
   assign pred_taken  = r_pred_taken;
   assign pred_target = r_pred_target;

   // ---------------------------------------------------------------
   // Update path
   // ---------------------------------------------------------------
   logic [BTB_IDX_W-1:0] w_up_idx;
   logic                 w_btb_wr;
   logic                 w_pht_wr;
   logic [PHT_IDX_W-1:0] w_up_pht_idx;
   logic [1:0]           w_up_ctr;
   logic [1:0]           w_up_ctr_nxt;
   logic                 w_ras_push;
   logic                 w_ras_pop;

   assign w_up_idx     = update_pc[BTB_IDX_W+1:2];
   assign w_btb_wr     = update_en && update_taken;
   assign w_pht_wr     = update_en && (update_type == TYPE_BRANCH);
   assign w_up_pht_idx = update_pc[PHT_IDX_W+1:2] ^ r_ghr;
   assign w_up_ctr     = r_pht[w_up_pht_idx];
   assign w_ras_push   = update_en && (update_type == TYPE_CALL);
   assign w_ras_pop    = update_en && (update_type == TYPE_RETURN) && !w_ras_empty;

   always_comb begin
      w_up_ctr_nxt = w_up_ctr;
      if (update_taken) begin
         if (w_up_ctr != 2'b11) w_up_ctr_nxt = w_up_ctr + 2'b01;
      end else begin
         if (w_up_ctr != 2'b00) w_up_ctr_nxt = w_up_ctr - 2'b01;
      end
   end

   // BTB valid bits are the only BTB state that needs a reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_btb_valid <= '0;
      end else if (w_btb_wr) begin
         r_btb_valid[w_up_idx] <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (w_btb_wr) begin
         r_btb_tag[w_up_idx]  <= update_pc[31:BTB_IDX_W+2];
         r_btb_tgt[w_up_idx]  <= update_target;
         r_btb_type[w_up_idx] <= update_type;
      end
   end

   // Counters start weakly not-taken.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < PHT_N; i++) begin
            r_pht[i] <= 2'b01;
         end
         r_ghr <= '0;
      end else if (w_pht_wr) begin
         r_pht[w_up_pht_idx] <= w_up_ctr_nxt;
         r_ghr               <= {r_ghr[PHT_IDX_W-2:0], update_taken};
      end
   end

   // A push onto a full stack simply advances the pointer, overwriting the
   // oldest entry; the count sticks at RAS_DEPTH.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ras_ptr <= '0;
         r_ras_cnt <= '0;
      end else if (w_ras_push) begin
         r_ras_ptr <= r_ras_ptr + RAS_PTR_ONE;
         if (r_ras_cnt != RAS_FULL) r_ras_cnt <= r_ras_cnt + RAS_CNT_ONE;
      end else if (w_ras_pop) begin
         r_ras_ptr <= w_ras_top_ptr;
         r_ras_cnt <= r_ras_cnt - RAS_CNT_ONE;
      end
   end

   // Return address skips the branch delay slot.
   always_ff @(posedge clk) begin
      if (w_ras_push) begin
         r_ras[r_ras_ptr] <= update_pc + 32'd8;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_misp_cnt <= 32'd0;
      end else if (update_en && update_mispredict && (r_misp_cnt != 32'hFFFF_FFFF)) begin
         r_misp_cnt <= r_misp_cnt + 32'd1;
      end
   end

   assign mispredict_cnt = r_misp_cnt;

   logic w_unused_pc_lsbs;
   assign w_unused_pc_lsbs = ^{lookup_pc[1:0], update_pc[1:0]};

endmodule

// File: tb/tb_branch_predictor.sv
// tb/tb_branch_predictor.sv - self-checking bench for branch_predictor

module tb_branch_predictor;

   logic        clk = 1'b0;
   logic        rst;
   logic        lookup_en;
   logic [31:0] lookup_pc;
   logic        pred_valid;
   logic        pred_hit;
   logic        pred_taken;
   logic [31:0] pred_target;
   logic        update_en;
   logic [31:0] update_pc;
   logic [1:0]  update_type;
   logic        update_taken;
   logic [31:0] update_target;
   logic        update_mispredict;
   logic [31:0] mispredict_cnt;

   always #5 clk = ~clk;

   branch_predictor #(.BTB_IDX_W(6), .PHT_IDX_W(8), .RAS_DEPTH(8)) dut (
      .clk               (clk),
      .rst               (rst),
      .lookup_en         (lookup_en),
      .lookup_pc         (lookup_pc),
      .pred_valid        (pred_valid),
      .pred_hit          (pred_hit),
      .pred_taken        (pred_taken),
      .pred_target       (pred_target),
      .update_en         (update_en),
      .update_pc         (update_pc),
      .update_type       (update_type),
      .update_taken      (update_taken),
      .update_target     (update_target),
      .update_mispredict (update_mispredict),
      .mispredict_cnt    (mispredict_cnt)
   );

   typedef struct {
      bit          rst_first;
      bit          upd_en;
      logic [31:0] upd_pc;
      logic [1:0]  upd_type;
      bit          upd_taken;
      logic [31:0] upd_tgt;
      bit          upd_misp;
      bit          lk_en;
      logic [31:0] lk_pc;
      bit          exp_hit;
      bit          exp_taken;
      logic [31:0] exp_tgt;
   } vec_t;

   typedef struct {
      bit          hit;
      bit          taken;
      logic [31:0] tgt;
   } exp_t;

   vec_t        tbl[$];
   exp_t        sb[$];
   int          errors = 0;
   int          checks = 0;
   bit          pend_rst = 1'b0;
   logic [31:0] exp_misp = 32'd0;
   logic [31:0] last_tgt = 32'd0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic add(input bit ue, input logic [31:0] upc, input logic [1:0] uty,
                      input bit utk, input logic [31:0] utgt, input bit umisp,
                      input bit le, input logic [31:0] lpc,
                      input bit eh, input bit et, input logic [31:0] etgt);
      vec_t v;
      v.rst_first = pend_rst;
      pend_rst    = 1'b0;
      v.upd_en    = ue;  v.upd_pc = upc; v.upd_type = uty; v.upd_taken = utk;
      v.upd_tgt   = utgt; v.upd_misp = umisp;
      v.lk_en     = le;  v.lk_pc = lpc;
      v.exp_hit   = eh;  v.exp_taken = et; v.exp_tgt = etgt;
      tbl.push_back(v);
   endtask

   task automatic upd(input logic [31:0] pc, input logic [1:0] ty, input bit tk,
                      input logic [31:0] tgt, input bit misp);
      add(1'b1, pc, ty, tk, tgt, misp, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
   endtask

   task automatic lk(input logic [31:0] pc, input bit eh, input bit et, input logic [31:0] etgt);
      add(1'b0, 32'd0, 2'd0, 1'b0, 32'd0, 1'b0, 1'b1, pc, eh, et, etgt);
   endtask

   task automatic idle_inputs();
      lookup_en = 1'b0; lookup_pc = 32'd0;
      update_en = 1'b0; update_pc = 32'd0; update_type = 2'd0;
      update_taken = 1'b0; update_target = 32'd0; update_mispredict = 1'b0;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_pred_valid"}, {31'd0, pred_valid}, 32'd0);
      check({tag, "_pred_hit"},   {31'd0, pred_hit},   32'd0);
      check({tag, "_pred_taken"}, {31'd0, pred_taken}, 32'd0);
      check({tag, "_pred_target"}, pred_target,        32'd0);
      check({tag, "_misp_cnt"},    mispredict_cnt,     32'd0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      idle_inputs();
      rst = 1'b1;
      #1;
      check_all_zero("grp_rst");
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      exp_misp = 32'd0;
      last_tgt = 32'd0;
   endtask

   task automatic build_table();
      // Cold miss straight out of reset
      lk(32'h0040_0000, 1'b0, 1'b0, 32'h0040_0004);
      // Counter training: warm history to all-ones so the trained counter is
      // the one the lookup indexes, then train twice.
      for (int k = 0; k < 8; k++) upd(32'h0040_0010, 2'd0, 1'b1, 32'h0040_0100, 1'b0);
      upd(32'h0040_0010, 2'd0, 1'b1, 32'h0040_0100, 1'b0);
      upd(32'h0040_0010, 2'd0, 1'b1, 32'h0040_0100, 1'b0);
      lk(32'h0040_0010, 1'b1, 1'b1, 32'h0040_0100);
      for (int k = 0; k < 4; k++) upd(32'h0040_0010, 2'd0, 1'b0, 32'h0040_0100, 1'b1);
      lk(32'h0040_0010, 1'b1, 1'b0, 32'h0040_0014);
      // Call / return
      upd(32'h0040_0020, 2'd2, 1'b1, 32'h0040_1000, 1'b0);
      upd(32'h0040_1010, 2'd3, 1'b1, 32'h0040_0028, 1'b1);
      lk(32'h0040_1010, 1'b1, 1'b1, 32'h0040_0028);
      upd(32'h0040_0020, 2'd2, 1'b1, 32'h0040_1000, 1'b0);
      upd(32'h0040_0040, 2'd2, 1'b1, 32'h0040_1000, 1'b0);
      lk(32'h0040_1010, 1'b1, 1'b1, 32'h0040_0048);
      add(1'b1, 32'h0040_0060, 2'd2, 1'b1, 32'h0040_1000, 1'b0,
          1'b1, 32'h0040_1010, 1'b1, 1'b1, 32'h0040_0048);
      lk(32'h0040_1010, 1'b1, 1'b1, 32'h0040_0068);
      lk(32'h0040_0020, 1'b1, 1'b1, 32'h0040_1000);
      add(1'b0, 32'd0, 2'd0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);

      // RAS overflow
      pend_rst = 1'b1;
      upd(32'h0060_0010, 2'd3, 1'b1, 32'h0070_0000, 1'b0);
      lk(32'h0060_0010, 1'b1, 1'b1, 32'h0070_0000);
      for (int k = 0; k <= 8; k++)
         upd(32'h0050_0000 + 32'(k) * 32'h40, 2'd2, 1'b1, 32'h0060_0010, 1'b0);
      for (int j = 8; j >= 1; j--)
         add(1'b1, 32'h0060_0010, 2'd3, 1'b1, 32'h0070_0000, 1'b0,
             1'b1, 32'h0060_0010, 1'b1, 1'b1, 32'h0050_0008 + 32'(j) * 32'h40);
      add(1'b1, 32'h0060_0010, 2'd3, 1'b1, 32'h0070_0000, 1'b0,
          1'b1, 32'h0060_0010, 1'b1, 1'b1, 32'h0070_0000);
      lk(32'h0060_0010, 1'b1, 1'b1, 32'h0070_0000);
      upd(32'h0050_0400, 2'd2, 1'b1, 32'h0060_0010, 1'b0);
      lk(32'h0060_0010, 1'b1, 1'b1, 32'h0050_0408);

      // Aliasing, same-cycle update, no allocation on not-taken
      pend_rst = 1'b1;
      upd(32'h0040_0044, 2'd0, 1'b1, 32'h0040_0400, 1'b0);
      lk(32'h0040_0044, 1'b1, 1'b0, 32'h0040_0048);
      upd(32'h0040_0000, 2'd1, 1'b1, 32'h0040_0200, 1'b0);
      upd(32'h0040_0100, 2'd1, 1'b1, 32'h0040_0300, 1'b0);
      lk(32'h0040_0000, 1'b0, 1'b0, 32'h0040_0004);
      lk(32'h0040_0100, 1'b1, 1'b1, 32'h0040_0300);
      add(1'b1, 32'h0040_0888, 2'd1, 1'b1, 32'h0040_0900, 1'b0,
          1'b1, 32'h0040_0888, 1'b0, 1'b0, 32'h0040_088C);
      lk(32'h0040_0888, 1'b1, 1'b1, 32'h0040_0900);
      upd(32'h0040_0030, 2'd0, 1'b0, 32'h0040_0500, 1'b1);
      lk(32'h0040_0030, 1'b0, 1'b0, 32'h0040_0034);
      upd(32'h0040_0100, 2'd0, 1'b0, 32'h0040_0700, 1'b0);
      lk(32'h0040_0100, 1'b1, 1'b1, 32'h0040_0300);
      add(1'b0, 32'd0, 2'd0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      exp_t e;
      rst = 1'b0;
      idle_inputs();
      build_table();
      #2 rst = 1'b1;
      #1;
      check_all_zero("por");
      @(negedge clk);
      rst = 1'b0;

      foreach (tbl[i]) begin
         if (tbl[i].rst_first) do_reset();
         @(negedge clk);
         update_en         = tbl[i].upd_en;
         update_pc         = tbl[i].upd_pc;
         update_type       = tbl[i].upd_type;
         update_taken      = tbl[i].upd_taken;
         update_target     = tbl[i].upd_tgt;
         update_mispredict = tbl[i].upd_misp;
         lookup_en         = tbl[i].lk_en;
         lookup_pc         = tbl[i].lk_pc;
         if (tbl[i].lk_en) begin
            e.hit = tbl[i].exp_hit; e.taken = tbl[i].exp_taken; e.tgt = tbl[i].exp_tgt;
            sb.push_back(e);
         end
         if (tbl[i].upd_en && tbl[i].upd_misp && exp_misp != 32'hFFFF_FFFF)
            exp_misp = exp_misp + 32'd1;
         @(posedge clk);
         #1;
         check($sformatf("v%0d_pred_valid", i), {31'd0, pred_valid}, {31'd0, tbl[i].lk_en});
         if (tbl[i].lk_en) begin
            e = sb.pop_front();
            check($sformatf("v%0d_hit", i),    {31'd0, pred_hit},   {31'd0, e.hit});
            check($sformatf("v%0d_taken", i),  {31'd0, pred_taken}, {31'd0, e.taken});
            check($sformatf("v%0d_target", i), pred_target,          e.tgt);
            last_tgt = e.tgt;
         end else begin
            check($sformatf("v%0d_target_hold", i), pred_target, last_tgt);
         end
         check($sformatf("v%0d_misp_cnt", i), mispredict_cnt, exp_misp);
      end
      check("scoreboard_empty", sb.size(), 32'd0);

      // Mispredict counter saturation
      @(negedge clk);
      idle_inputs();
      force dut.r_misp_cnt = 32'hFFFF_FFFF;
      #1;
      release dut.r_misp_cnt;
      check("misp_cnt_preset", mispredict_cnt, 32'hFFFF_FFFF);
      update_en = 1'b1; update_pc = 32'h0040_0200; update_type = 2'd1;
      update_taken = 1'b1; update_target = 32'h0040_0600; update_mispredict = 1'b1;
      @(posedge clk);
      #1;
      check("misp_cnt_saturate", mispredict_cnt, 32'hFFFF_FFFF);

      // Asynchronous reset between edges discards the pending lookup
      @(negedge clk);
      idle_inputs();
      lookup_en = 1'b1; lookup_pc = 32'h0040_0200;
      @(posedge clk);
      #1;
      check("pre_rst_valid", {31'd0, pred_valid}, 32'd1);
      check("pre_rst_target", pred_target, 32'h0040_0600);
      #2 rst = 1'b1;
      #1;
      check_all_zero("async_rst");
      @(negedge clk);
      rst = 1'b0;
      lookup_en = 1'b0;
      @(posedge clk);
      #1;
      check("post_rst_valid", {31'd0, pred_valid}, 32'd0);
      check("post_rst_target", pred_target, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
